// File: rtl/scratch_pad_issue_pkg.sv
// Shared types and defaults for the scratch pad issue queue.
package scratch_pad_issue_pkg;
`include "common.vh"

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int SPI_WIDTH      = 64;
  localparam int SPI_ADDR_WIDTH = 12;
  localparam int SPI_FIFO_DEPTH = 32;
  localparam int SPI_MAX_OUTST  = 32;
endpackage

// File: rtl/common.vh
// Shared helpers included by every scratch pad block.
`ifndef COMMON_VH
`define COMMON_VH
// Ceiling log2; log2(1) = 0.
function automatic integer log2(input integer v);
  log2 = 0;
  while ((1 << log2) < v) log2 = log2 + 1;
endfunction
`endif

// File: rtl/scratch_pad_issue_fifo.sv
// First-word-fall-through request queue; head is valid whenever !empty.
module scratch_pad_issue_fifo
  import scratch_pad_issue_pkg::*;
#(
  parameter int W     = 77,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = log2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !rst;
  assign do_pop  = pop && !empty && !rst;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset; count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/scratch_pad_issue.sv
// Issues queued reads/writes to the scratch pad, gating reads on return credit.
module scratch_pad_issue
  import scratch_pad_issue_pkg::*;
#(
  parameter int WIDTH           = SPI_WIDTH,
  parameter int ADDR_WIDTH      = SPI_ADDR_WIDTH,
  parameter int FIFO_DEPTH      = SPI_FIFO_DEPTH,
  parameter int MAX_OUTSTANDING = SPI_MAX_OUTST
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push,
  input  logic                                 push_wr,
  input  logic [ADDR_WIDTH-1:0]                push_addr,
  input  logic [WIDTH-1:0]                     push_d,
  output logic                                 push_full,
  output logic                                 rd_en,
  output logic                                 wr_en,
  output logic [ADDR_WIDTH-1:0]                addr,
  output logic [WIDTH-1:0]                     d,
  input  logic                                 full,
  input  logic                                 valid,
  input  logic                                 stall,
  output logic [log2(MAX_OUTSTANDING):0]       outstanding,
  output logic                                 empty,
  output logic                                 err
);
  localparam int OW = log2(MAX_OUTSTANDING) + 1;

  typedef struct packed {
    op_e                   op;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      d;
  } req_t;

  req_t push_req, head;
  logic blocked, issue, retire, credit_out;

  assign push_req = '{op: op_e'(push_wr), addr: push_addr, d: push_d};

  scratch_pad_issue_fifo #(
    .W     ($bits(req_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_req),
    .pop   (issue),
    .dout  (head),
    .full  (push_full),
    .empty (empty)
  );

  // A credit-starved read at the head also holds back writes queued behind it.
  assign credit_out = (outstanding == OW'(MAX_OUTSTANDING));
  assign blocked    = full || (head.op == OP_RD && credit_out);
  assign issue      = !rst && !empty && !blocked;
  assign rd_en      = issue && (head.op == OP_RD);
  assign wr_en      = issue && (head.op == OP_WR);
  assign addr       = head.addr;
  assign d          = head.d;
  assign retire     = valid && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (retire && outstanding == '0) err <= 1'b1;
      if (rd_en && !retire)
        outstanding <= outstanding + 1'b1;
      else if (!rd_en && retire && outstanding != '0)
        outstanding <= outstanding - 1'b1;
    end
  end

  a_one_hot_issue: assert property (@(posedge clk) !(rd_en && wr_en));
  a_credit_bound:  assert property (@(posedge clk) disable iff (rst)
                                    outstanding <= OW'(MAX_OUTSTANDING));
endmodule
